// File: rtl/fp_pkg.sv
// Shared constants and types for the 8-bit floating-point code path.
package fp_pkg;

    // Field widths of the code and width of the linear value
    localparam int unsigned EXP_W  = 3;
    localparam int unsigned SIG_W  = 4;
    localparam int unsigned LIN_W  = 12;
    localparam int unsigned CODE_W = 1 + EXP_W + SIG_W;

    // Field positions within the code {S, E, F}
    localparam int unsigned F_LSB = 0;
    localparam int unsigned E_LSB = SIG_W;
    localparam int unsigned S_POS = SIG_W + EXP_W;

    // Decoder sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSign,
        StDone
    } state_e;

endpackage

// File: rtl/sign_apply.sv
// Combinational sign stage: turns sign + magnitude into a two's-complement value.
module sign_apply #(
    parameter int unsigned MAG_W = 11
) (
    input  logic             sign_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic [MAG_W:0]   value_o
);

    logic [MAG_W:0] ext;

    // Negating zero yields zero, so a negative-zero code needs no special case
    always_comb begin
        ext     = {1'b0, mag_i};
        value_o = sign_i ? (~ext + (MAG_W + 1)'(1)) : ext;
    end

endmodule

// File: rtl/fp_decoder.sv
// Iterative decoder: rebuilds the magnitude one left shift per cycle, then signs it.
module fp_decoder #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned SIG_W = 4,
    parameter int unsigned LIN_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   fp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LIN_W-1:0]       linear_out
);

    import fp_pkg::state_e;
    import fp_pkg::StIdle;
    import fp_pkg::StShift;
    import fp_pkg::StSign;
    import fp_pkg::StDone;

    // Magnitude excludes the sign bit; field positions follow the parameters
    localparam int unsigned MAG_W   = LIN_W - 1;
    localparam int unsigned S_BIT   = EXP_W + SIG_W;
    localparam int unsigned EXP_LSB = SIG_W;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [LIN_W-1:0]   lin_q, lin_d;
    logic               out_valid_q, out_valid_d;
    logic [LIN_W-1:0]   signed_val;

    sign_apply #(
        .MAG_W (MAG_W)
    ) u_sign_apply (
        .sign_i  (sign_q),
        .mag_i   (mag_q),
        .value_o (signed_val)
    );

    // Next-state logic for the sequencer and the datapath registers
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        lin_d       = lin_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = fp_in[S_BIT];
                    cnt_d   = fp_in[EXP_LSB +: EXP_W];
                    mag_d   = MAG_W'(fp_in[SIG_W-1:0]);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    state_d = StSign;
                end
            end
            StSign: begin
                lin_d       = signed_val;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            mag_q       <= '0;
            lin_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            lin_q       <= lin_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs: ready only while idle; result comes straight from registers
    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = out_valid_q;
        linear_out = lin_q;
    end

endmodule

// File: tb/tb_fp_decoder.sv
// Scoreboard bench for fp_decoder: directed codes with hand-computed results.
module tb_fp_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] linear_out;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    fp_decoder #(
        .EXP_W (3),
        .SIG_W (4),
        .LIN_W (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fp_in      (fp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .linear_out (linear_out)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every transfer seen must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", linear_out);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (linear_out !== e) begin
                    errors++;
                    $display("FAIL result: got 0x%0h, expected 0x%0h", linear_out, e);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", 0, 1);
    endtask

    // Present one code for a single accepting edge; returns cycles until out_valid
    task automatic issue(input logic [7:0] code, output int lat);
        wait_ready();
        in_valid = 1'b1;
        fp_in    = code;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fp_in    = 8'h5A;  // later changes must not affect the latched code
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction with out_ready held high
    task automatic run_code(input logic [7:0] code, input logic [11:0] expv, input string name);
        int lat;
        exp_q.push_back(expv);
        issue(code, lat);
        check({name, "_latency"}, lat, int'(code[6:4]) + 2);
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, int'(out_valid), 0);
        check({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        fp_in     = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_linear", int'(linear_out), 0);

        run_code(8'h00, 12'h000, "zero");
        run_code(8'h7F, 12'h780, "max_pos");
        run_code(8'hFF, 12'h880, "max_neg");
        run_code(8'hAB, 12'hFD4, "neg44");
        run_code(8'h35, 12'h028, "pos40");
        run_code(8'h8F, 12'hFF1, "neg15_e0");
        run_code(8'hD0, 12'h000, "neg_zero");

        // Stall: result must hold while out_ready is low, other codes ignored
        out_ready = 1'b0;
        exp_q.push_back(12'hFEC);
        issue(8'h9A, lat);
        check("stall_latency", lat, 3);
        in_valid = 1'b1;
        fp_in    = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_linear", int'(linear_out), 12'hFEC);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_valid_drop", int'(out_valid), 0);
        check("stall_ready_back", int'(in_ready), 1);
        repeat (15) @(posedge clk);
        #1;
        check("stall_no_extra", int'(out_valid), 0);

        // Put a nonzero value on linear_out so the reset check below means something
        run_code(8'h7F, 12'h780, "pre_abort");

        // Abort mid-shift: no result may ever appear for this code
        wait_ready();
        in_valid = 1'b1;
        fp_in    = 8'h7F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", int'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_linear", int'(linear_out), 0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_output", int'(out_valid), 0);

        // Decoder must still work normally afterwards
        run_code(8'hAB, 12'hFD4, "post_abort");

        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
